// File: rtl/fpnew_pkg.sv
// Shared FPU definitions used by the result reorder buffer.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//   NUM_OPGROUPS  : default number of operation-group result channels
//   status_t      : IEEE-754 exception flags returned with every result
//   rob_id_width  : sequence-ID width for a reorder buffer of a given depth
package fpnew_pkg;

  localparam int unsigned NUM_OPGROUPS = 4;

  typedef struct packed {
    logic NV; // invalid operation
    logic DZ; // divide by zero
    logic OF; // overflow
    logic UF; // underflow
    logic NX; // inexact
  } status_t;

  // Never returns 0 so that a 1-entry configuration still has a legal ID port.
  function automatic int unsigned rob_id_width(input int unsigned depth);
    return (depth > 1) ? unsigned'($clog2(depth)) : 1;
  endfunction

  // Reorder-buffer entries follow this layout. The struct itself is declared
  // inside fpnew_rob_arbiter because it depends on Width and TagType:
  //   struct packed { logic alloc; logic done;
  //                   logic [Width-1:0] result; status_t status; TagType tag; }

endpackage

// File: rtl/fpnew_rob_wrsel.sv
// Per-entry selection of the result channel allowed to write each ROB entry.
// Latency: purely combinational.
// Backpressure: a channel is refused when its ID is not open, is claimed by a lower valid channel, or during flush.
//   flush_i     : discard in progress, refuse every channel
//   open_i      : per entry, allocated and still waiting for its result
//   res_valid_i : per-channel result valid
//   res_id_i    : per-channel target sequence ID
//   res_ready_o : per-channel accept
//   grant_o     : per entry, one-hot (or zero) vector of the writing channel
module fpnew_rob_wrsel
  import fpnew_pkg::*;
#(
  parameter int unsigned NumIn = 4,
  parameter int unsigned Depth = 4,
  localparam int unsigned IdW  = rob_id_width(Depth)
) (
  input  logic                        flush_i,
  input  logic [Depth-1:0]            open_i,
  input  logic [NumIn-1:0]            res_valid_i,
  input  logic [NumIn-1:0][IdW-1:0]   res_id_i,
  output logic [NumIn-1:0]            res_ready_o,
  output logic [Depth-1:0][NumIn-1:0] grant_o
);

  // A channel is shadowed when a lower-indexed valid channel targets the same ID.
  logic [NumIn-1:0] shadowed;

  always_comb begin
    shadowed = '0;
    for (int unsigned i = 1; i < NumIn; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        if (res_valid_i[j] && (res_id_i[j] == res_id_i[i])) begin
          shadowed[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    res_ready_o = '0;
    grant_o     = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      res_ready_o[i] = open_i[res_id_i[i]] && !shadowed[i] && !flush_i;
      grant_o[res_id_i[i]][i] = res_valid_i[i] && res_ready_o[i];
    end
  end

endmodule

// File: rtl/fpnew_rob_arbiter.sv
// In-order collector: hands out sequence IDs, buffers out-of-order results, releases them in issue order.
// Latency: ID is combinational at allocation; a result written to the head entry is presented the next cycle.
// Backpressure: alloc stalls while full (no retire bypass); results stall on closed IDs; head holds while out_ready_i is low.
//   clk_i / rst_ni          : clock, asynchronous active-low reset
//   flush_i                 : drop every in-flight entry
//   alloc_valid_i/_ready_o  : dispatch handshake, alloc_id_o is the assigned ID
//   res_*_i / res_ready_o   : NumIn result channels, each tagged with its sequence ID
//   out_valid_o/out_ready_i : in-order output of result_o, status_o, tag_o
//   count_o / busy_o        : occupancy
module fpnew_rob_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumIn = fpnew_pkg::NUM_OPGROUPS,
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4,
  parameter type         TagType = logic,
  localparam int unsigned IdW  = rob_id_width(Depth)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            alloc_valid_i,
  output logic                            alloc_ready_o,
  output logic [IdW-1:0]                  alloc_id_o,
  input  logic [NumIn-1:0]                res_valid_i,
  output logic [NumIn-1:0]                res_ready_o,
  input  logic [NumIn-1:0][IdW-1:0]       res_id_i,
  input  logic [NumIn-1:0][Width-1:0]     res_result_i,
  input  status_t [NumIn-1:0]             res_status_i,
  input  TagType [NumIn-1:0]              res_tag_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [Width-1:0]                result_o,
  output status_t                         status_o,
  output TagType                          tag_o,
  output logic [IdW:0]                    count_o,
  output logic                            busy_o
);

  typedef struct packed {
    logic             alloc;
    logic             done;
    logic [Width-1:0] result;
    status_t          status;
    TagType           tag;
  } rob_entry_t;

  localparam logic [IdW:0] PtrInc = (IdW+1)'(1);

  rob_entry_t [Depth-1:0] entry_q, entry_d;
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [IdW:0]           head_q, head_d, tail_q, tail_d;
  logic [IdW-1:0]         head_idx, tail_idx;
  logic                   empty, full;
  logic                   alloc_fire, retire_fire;
  logic [Depth-1:0]       open;
  logic [Depth-1:0][NumIn-1:0] grant;

  assign head_idx = head_q[IdW-1:0];
  assign tail_idx = tail_q[IdW-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IdW] != tail_q[IdW]);

  // Full blocks allocation even if the head retires this cycle: keeps
  // out_ready_i off the alloc_ready_o path.
  assign alloc_ready_o = !full && !flush_i;
  assign alloc_id_o    = tail_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign out_valid_o = !empty && entry_q[head_idx].done;
  assign result_o    = entry_q[head_idx].result;
  assign status_o    = entry_q[head_idx].status;
  assign tag_o       = entry_q[head_idx].tag;
  // Flush is not folded in here: the flush branch below overrides everything.
  assign retire_fire = out_valid_o && out_ready_i;

  assign count_o = tail_q - head_q;
  assign busy_o  = (count_o != '0);

  always_comb begin
    open = '0;
    for (int unsigned e = 0; e < Depth; e++) begin
      open[e] = entry_q[e].alloc && !entry_q[e].done;
    end
  end

  fpnew_rob_wrsel #(
    .NumIn (NumIn),
    .Depth (Depth)
  ) u_wrsel (
    .flush_i     (flush_i),
    .open_i      (open),
    .res_valid_i (res_valid_i),
    .res_id_i    (res_id_i),
    .res_ready_o (res_ready_o),
    .grant_o     (grant)
  );

  // Alloc, write and retire never touch the same entry in one cycle:
  // tail is unallocated unless full (then no alloc), head is done so it
  // cannot be written, and head == tail with an entry only when full.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      // Payload fields are left as they are; only the state bits matter.
      for (int unsigned e = 0; e < Depth; e++) begin
        entry_d[e].alloc = 1'b0;
        entry_d[e].done  = 1'b0;
      end
    end else begin
      for (int unsigned e = 0; e < Depth; e++) begin
        for (int unsigned i = 0; i < NumIn; i++) begin
          if (grant[e][i]) begin
            entry_d[e].result = res_result_i[i];
            entry_d[e].status = res_status_i[i];
            entry_d[e].tag    = res_tag_i[i];
            entry_d[e].done   = 1'b1;
          end
        end
      end
      if (alloc_fire) begin
        entry_d[tail_idx].alloc = 1'b1;
        entry_d[tail_idx].done  = 1'b0;
        tail_d = tail_q + PtrInc;
      end
      if (retire_fire) begin
        entry_d[head_idx].alloc = 1'b0;
        entry_d[head_idx].done  = 1'b0;
        head_d = head_q + PtrInc;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_fpnew_rob_arbiter.sv
// Bench for fpnew_rob_arbiter: directed scenarios followed by random traffic,
// all checked against an issue-order queue model of the reorder buffer.
module tb_fpnew_rob_arbiter;
  localparam int NI = 4;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int IW = 2;
  typedef logic [3:0] tag_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      flush = 1'b0;
  logic                      alloc_valid = 1'b0;
  logic                      alloc_ready;
  logic [IW-1:0]             alloc_id;
  logic [NI-1:0]             res_valid = '0;
  logic [NI-1:0]             res_ready;
  logic [NI-1:0][IW-1:0]     res_id = '0;
  logic [NI-1:0][W-1:0]      res_result = '0;
  fpnew_pkg::status_t [NI-1:0] res_status = '0;
  tag_t [NI-1:0]             res_tag = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [W-1:0]              result;
  fpnew_pkg::status_t        status;
  tag_t                      tag;
  logic [IW:0]               count;
  logic                      busy;

  fpnew_rob_arbiter #(
    .NumIn   (NI),
    .Width   (W),
    .Depth   (D),
    .TagType (tag_t)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .alloc_valid_i (alloc_valid),
    .alloc_ready_o (alloc_ready),
    .alloc_id_o    (alloc_id),
    .res_valid_i   (res_valid),
    .res_ready_o   (res_ready),
    .res_id_i      (res_id),
    .res_result_i  (res_result),
    .res_status_i  (res_status),
    .res_tag_i     (res_tag),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .result_o      (result),
    .status_o      (status),
    .tag_o         (tag),
    .count_o       (count),
    .busy_o        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding operations in issue order.
  typedef struct {
    int          id;
    bit          done;
    logic [15:0] res;
    logic [4:0]  st;
    logic [3:0]  tg;
  } op_t;
  op_t q[$];
  int  next_id = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic int find(input int id);
    for (int k = 0; k < q.size(); k++) if (q[k].id == id) return k;
    return -1;
  endfunction

  task automatic wr(input int ch, input int id, input logic [15:0] r,
                    input logic [4:0] st, input logic [3:0] tg);
    res_valid[ch]  = 1'b1;
    res_id[ch]     = IW'(id);
    res_result[ch] = r;
    res_status[ch] = st;
    res_tag[ch]    = tg;
  endtask

  // One clock: compare against the model, then advance model and DUT.
  task automatic tick();
    bit            e_full;
    bit            e_ovld;
    bit            rdy;
    int            idx;
    logic [NI-1:0] e_rrdy;
    op_t           o;
    #1;
    e_full = (q.size() == D);
    check("alloc_ready", 32'(alloc_ready), 32'(!e_full && !flush));
    check("alloc_id", 32'(alloc_id), 32'(next_id));
    check("count", 32'(count), 32'(q.size()));
    check("busy", 32'(busy), 32'(q.size() != 0));
    e_rrdy = '0;
    for (int i = 0; i < NI; i++) begin
      idx = find(int'(res_id[i]));
      rdy = !flush && (idx >= 0) && !q[idx].done;
      for (int j = 0; j < i; j++)
        if (res_valid[j] && res_id[j] == res_id[i]) rdy = 1'b0;
      e_rrdy[i] = rdy;
    end
    check("res_ready", 32'(res_ready), 32'(e_rrdy));
    e_ovld = (q.size() > 0) && q[0].done;
    check("out_valid", 32'(out_valid), 32'(e_ovld));
    if (e_ovld) begin
      check("result", 32'(result), 32'(q[0].res));
      check("status", 32'(status), 32'(q[0].st));
      check("tag", 32'(tag), 32'(q[0].tg));
    end
    @(posedge clk);
    if (flush) begin
      q.delete();
      next_id = 0;
    end else begin
      if (e_ovld && out_ready) void'(q.pop_front());
      for (int i = 0; i < NI; i++) begin
        if (res_valid[i] && e_rrdy[i]) begin
          idx = find(int'(res_id[i]));
          q[idx].done = 1'b1;
          q[idx].res  = res_result[i];
          q[idx].st   = res_status[i];
          q[idx].tg   = res_tag[i];
        end
      end
      if (alloc_valid && !e_full) begin
        o.id = next_id; o.done = 1'b0; o.res = '0; o.st = '0; o.tg = '0;
        q.push_back(o);
        next_id = (next_id + 1) % D;
      end
    end
    #1;
  endtask

  initial begin
    logic [15:0] exp_res;
    int          pick;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_id", 32'(alloc_id), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_tag", 32'(tag), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    rst_n = 1'b1;

    // Four allocations fill the buffer with IDs 0..3
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1'b1;
      #1; check("fill_id", 32'(alloc_id), 32'(k));
      tick();
    end
    alloc_valid = 1'b0;
    #1;
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    tick();

    // Out-of-order return: ID2 first, then ID0
    out_ready = 1'b1;
    wr(0, 2, 16'h3C00, 5'h01, 4'h2);
    #1;
    check("ooo_ready_id2", 32'(res_ready[0]), 32'd1);
    check("ooo_no_out_a", 32'(out_valid), 32'd0);
    tick();
    wr(0, 0, 16'h4000, 5'h00, 4'h0);
    #1; check("ooo_no_out_b", 32'(out_valid), 32'd0);
    tick();

    // Head ready; dual write of IDs 1 and 3; full + retire must not allocate
    wr(0, 1, 16'h4200, 5'h10, 4'h1);
    wr(1, 3, 16'h5000, 5'h04, 4'h3);
    alloc_valid = 1'b1;
    #1;
    check("ooo_first", 32'(result), 32'h4000);
    check("ooo_first_vld", 32'(out_valid), 32'd1);
    check("dual_ready", 32'(res_ready[1:0]), 32'h3);
    check("full_retire_no_alloc", 32'(alloc_ready), 32'd0);
    tick();

    // Allocation succeeds one cycle later with the wrapped ID 0
    res_valid = '0;
    out_ready = 1'b0;
    #1;
    check("wrap_alloc_ready", 32'(alloc_ready), 32'd1);
    check("wrap_alloc_id", 32'(alloc_id), 32'd0);
    tick();
    alloc_valid = 1'b0;

    // Backpressure: head contents stable for 5 cycles
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_count", 32'(count), 32'd4);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'h4200);
      check("bp_status", 32'(status), 32'h10);
      check("bp_tag", 32'(tag), 32'h1);
      tick();
    end

    // Release: in-order drain
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_res = (k == 0) ? 16'h4200 : (k == 1) ? 16'h3C00 : 16'h5000;
      #1;
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_result", 32'(result), 32'(exp_res));
      tick();
    end
    #1;
    check("drain_stop", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count), 32'd1);
    tick();

    // Flush with three entries pending
    alloc_valid = 1'b1;
    tick(); tick();
    flush = 1'b1;
    wr(0, 2, 16'h9999, 5'h00, 4'h9);
    #1;
    check("flush_alloc_ready", 32'(alloc_ready), 32'd0);
    check("flush_res_ready", 32'(res_ready[0]), 32'd0);
    tick();
    flush = 1'b0;
    wr(0, 1, 16'hDEAD, 5'h00, 4'hD);
    #1;
    check("post_flush_count", 32'(count), 32'd0);
    check("post_flush_valid", 32'(out_valid), 32'd0);
    check("stale_ready", 32'(res_ready[0]), 32'd0);
    check("post_flush_id", 32'(alloc_id), 32'd0);
    tick();
    res_valid = '0;
    tick();

    // Collision: two channels on ID1, lowest index wins
    alloc_valid = 1'b0;
    wr(0, 1, 16'hAAAA, 5'h02, 4'h5);
    wr(1, 1, 16'hBBBB, 5'h08, 4'h6);
    wr(2, 0, 16'h1234, 5'h00, 4'h7);
    #1;
    check("coll_ch0", 32'(res_ready[0]), 32'd1);
    check("coll_ch1", 32'(res_ready[1]), 32'd0);
    check("coll_ch2", 32'(res_ready[2]), 32'd1);
    tick();
    res_valid = '0;
    #1; check("coll_out0", 32'(result), 32'h1234);
    tick();
    #1;
    check("coll_out1", 32'(result), 32'hAAAA);
    check("coll_tag1", 32'(tag), 32'h5);
    tick();
    #1; check("coll_empty", 32'(out_valid), 32'd0);
    tick();

    // Asynchronous reset in the middle of traffic
    alloc_valid = 1'b1;
    out_ready = 1'b0;
    tick(); tick();
    alloc_valid = 1'b0;
    wr(0, 2, 16'h7777, 5'h03, 4'hA);
    tick();
    res_valid = '0;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_alloc_id", 32'(alloc_id), 32'd0);
    q.delete();
    next_id = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      alloc_valid = ($urandom_range(0, 9) < 6);
      out_ready   = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NI; i++) begin
        res_valid[i] = ($urandom_range(0, 2) == 0);
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          pick = int'($urandom_range(0, q.size() - 1));
          res_id[i] = IW'(q[pick].id);
        end else begin
          res_id[i] = IW'($urandom_range(0, D - 1));
        end
        res_result[i] = 16'($urandom);
        res_status[i] = 5'($urandom);
        res_tag[i]    = 4'($urandom);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
